// File: rtl/usbh_report_mux.sv
// HID host report multiplexer: captures per-channel reports (optionally dropping duplicates),
// counts them, and shows one channel selected manually, by timed scan, or by latest activity.
module usbh_report_mux #(
   parameter int C_channels      = 3,
   parameter int C_report_length = 20,
   parameter int C_filter_dup    = 1,
   parameter int C_scan_cycles   = 6000000,
   parameter int C_count_bits    = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [C_channels*C_report_length*8-1:0]    hid_report,
   input  logic [C_channels-1:0]                      hid_valid,
   input  logic [1:0]                                 mode,
   input  logic [1:0]                                 sel,
   output logic [C_report_length*8-1:0]               out_report,
   output logic                                       out_valid,
   output logic [1:0]                                 out_channel,
   output logic [C_channels*C_count_bits-1:0]         report_count
);

   localparam int RW     = C_report_length * 8;
   localparam int CB     = C_count_bits;
   localparam int SCAN_W = (C_scan_cycles > 1) ? $clog2(C_scan_cycles) : 1;

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(C_scan_cycles - 1);
   localparam logic [1:0]        CH_LAST   = 2'(C_channels - 1);
   localparam logic [2:0]        CH_NUM    = 3'(C_channels);

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'd0,
      MODE_SCAN   = 2'd1,
      MODE_FOLLOW = 2'd2
   } mode_e;

   logic [RW-1:0]         r_report_q [C_channels];
   logic [RW-1:0]         r_report_d [C_channels];
   logic [CB-1:0]         count_q    [C_channels];
   logic [CB-1:0]         count_d    [C_channels];
   logic [C_channels-1:0] acc_d, acc_q;
   logic [1:0]            cur_d, cur_q;
   logic [SCAN_W-1:0]     scan_d, scan_q;
   mode_e                 mode_eff, mode_q;
   logic [RW-1:0]         out_report_d, out_report_q;
   logic                  out_valid_d, out_valid_q;

   always_comb begin
      unique case (mode)
         2'd1:    mode_eff = MODE_SCAN;
         2'd2:    mode_eff = MODE_FOLLOW;
         default: mode_eff = MODE_MANUAL;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      acc_d = '0;
      for (int i = 0; i < C_channels; i++) begin
         r_report_d[i] = r_report_q[i];
         count_d[i]    = count_q[i];
         if (hid_valid[i] &&
             (C_filter_dup == 0 || hid_report[i*RW +: RW] != r_report_q[i])) begin
            acc_d[i]      = 1'b1;
            r_report_d[i] = hid_report[i*RW +: RW];
            count_d[i]    = count_q[i] + CB'(1);
         end
      end
   end

   always_comb begin
      cur_d = cur_q;
      unique case (mode_eff)
         MODE_MANUAL: cur_d = ({1'b0, sel} < CH_NUM) ? sel : 2'd0;
         MODE_SCAN: begin
            if (scan_q == SCAN_LAST) cur_d = (cur_q == CH_LAST) ? 2'd0 : cur_q + 2'd1;
         end
         MODE_FOLLOW: begin
            // Descending walk so the lowest accepted channel wins.
            for (int i = C_channels - 1; i >= 0; i--) begin
               if (acc_d[i]) cur_d = 2'(i);
            end
         end
         default: cur_d = cur_q;
      endcase
      if (C_channels == 1) cur_d = 2'd0;

      if (mode_eff != MODE_SCAN || mode_eff != mode_q || cur_d != cur_q || scan_q == SCAN_LAST)
         scan_d = '0;
      else
         scan_d = scan_q + SCAN_W'(1);
   end

   always_comb begin
      out_report_d = '0;
      out_valid_d  = 1'b0;
      for (int i = 0; i < C_channels; i++) begin
         if (cur_q == 2'(i)) begin
            out_report_d = r_report_q[i];
            out_valid_d  = acc_q[i];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values;
   // the stored reports are cleared on reset because duplicate filtering compares against them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < C_channels; i++) begin
            r_report_q[i] <= '0;
            count_q[i]    <= '0;
         end
         acc_q        <= '0;
         cur_q        <= 2'd0;
         scan_q       <= '0;
         out_report_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         for (int i = 0; i < C_channels; i++) begin
            r_report_q[i] <= r_report_d[i];
            count_q[i]    <= count_d[i];
         end
         acc_q        <= acc_d;
         cur_q        <= cur_d;
         scan_q       <= scan_d;
         out_report_q <= out_report_d;
         out_valid_q  <= out_valid_d;
      end
   end

   // Previous mode keeps tracking through reset so a held scan mode restarts with a full dwell.
   always_ff @(posedge clk) begin
      mode_q <= mode_eff;
   end

   always_comb begin
      report_count = '0;
      for (int i = 0; i < C_channels; i++) report_count[i*CB +: CB] = count_q[i];
   end

   assign out_report  = out_report_q;
   assign out_valid   = out_valid_q;
   assign out_channel = cur_q;

endmodule
